// File: rtl/timer_sched_pkg.sv
// Shared constants and types for the four-channel virtual timer block.
// Register offsets within a channel's window and CTRL bit positions live here.
package timer_sched_pkg;

  localparam int NCH = 4;

  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int EN   = 0;
  localparam int PER  = 1;
  localparam int IEN  = 2;
  localparam int PEND = 3;

  // Field order matches the CTRL read-back layout {pend, ien, periodic, en}.
  typedef struct packed {
    logic pend;
    logic ien;
    logic periodic;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_sched_chan.sv
// One timer channel: reload/count registers, control bits and the countdown
// performed when the scan pointer selects this channel.
module timer_sched_chan
  import timer_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        svc,
  input  logic        wr_reload,
  input  logic        wr_ctrl,
  input  logic        rd_status,
  input  logic [31:0] data_in,
  output logic [31:0] reload,
  output logic [31:0] count,
  output ctrl_t       ctrl
);

  logic expire;

  // A RELOAD write in the service slot replaces the count outright, so the
  // expiry that the old count would have produced is dropped with it.
  assign expire = svc && ctrl.en && (count == 32'd1) && !wr_reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      reload <= '1;
      count  <= '1;
      ctrl   <= '0;
    end else begin
      if (wr_reload) begin
        reload <= data_in;
        count  <= data_in;
      end else if (svc && ctrl.en) begin
        count <= expire ? reload : count - 32'd1;
      end

      if (wr_ctrl) begin
        ctrl.en       <= data_in[EN];
        ctrl.periodic <= data_in[PER];
        ctrl.ien      <= data_in[IEN];
      end else if (expire && !ctrl.periodic) begin
        ctrl.en <= 1'b0;
      end

      // Setting pend wins over a same-cycle STATUS read clear.
      if (expire) begin
        ctrl.pend <= 1'b1;
      end else if (rd_status) begin
        ctrl.pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Four virtual timers sharing one decrementer slot each via a rotating scan
// pointer, with a zero-wait-state register bus and level interrupt outputs.
module timer_sched
  import timer_sched_pkg::REG_RELOAD;
  import timer_sched_pkg::REG_COUNT;
  import timer_sched_pkg::REG_CTRL;
  import timer_sched_pkg::REG_STATUS;
  import timer_sched_pkg::ctrl_t;
#(
  parameter int NCH = timer_sched_pkg::NCH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stb,
  input  logic           we,
  input  logic [3:0]     addr,
  input  logic [31:0]    data_in,
  output logic [31:0]    data_out,
  output logic           ack,
  output logic           irq,
  output logic [NCH-1:0] irq_vec
);

  logic [1:0]  ptr;
  logic [1:0]  sel_ch;
  logic [1:0]  sel_reg;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] reload_q [NCH];
  logic [31:0] count_q  [NCH];
  ctrl_t       ctrl_q   [NCH];

  assign sel_ch  = addr[3:2];
  assign sel_reg = addr[1:0];
  assign bus_wr  = stb && we;
  assign bus_rd  = stb && !we;
  assign ack     = stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 2'd0;
    end else begin
      ptr <= ptr + 2'd1;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    timer_sched_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .svc       (ptr == 2'(gi)),
      .wr_reload (bus_wr && sel_ch == 2'(gi) && sel_reg == REG_RELOAD),
      .wr_ctrl   (bus_wr && sel_ch == 2'(gi) && sel_reg == REG_CTRL),
      .rd_status (bus_rd && sel_ch == 2'(gi) && sel_reg == REG_STATUS),
      .data_in   (data_in),
      .reload    (reload_q[gi]),
      .count     (count_q[gi]),
      .ctrl      (ctrl_q[gi])
    );
    assign irq_vec[gi] = ctrl_q[gi].pend & ctrl_q[gi].ien;
  end

  assign irq = |irq_vec;

  always_comb begin
    data_out = '0;
    case (sel_reg)
      REG_RELOAD: data_out = reload_q[sel_ch];
      REG_COUNT:  data_out = count_q[sel_ch];
      REG_CTRL:   data_out = {28'h0, ctrl_q[sel_ch]};
      REG_STATUS: data_out = {31'h0, ctrl_q[sel_ch].pend};
      default:    data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: reset table, directed corner sequences, then random
// bus traffic checked every cycle against a rule-level model of the timers.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        rst, stb, we, ack, irq;
  logic [3:0]  addr, irq_vec;
  logic [31:0] data_in, data_out;

  int checks = 0;
  int errors = 0;

  logic        last_irq;
  logic [3:0]  last_vec;
  logic [31:0] exp_q[$];

  // Behavioural model state
  logic [31:0] m_reload [4];
  logic [31:0] m_count  [4];
  bit          m_en [4], m_per [4], m_ien [4], m_pend [4];
  int          m_ptr;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t reset_tbl [16];

  always #5 clk = ~clk;

  timer_sched dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .irq      (irq),
    .irq_vec  (irq_vec)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_reload[i] = 32'hFFFF_FFFF;
      m_count[i]  = 32'hFFFF_FFFF;
      m_en[i] = 0; m_per[i] = 0; m_ien[i] = 0; m_pend[i] = 0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int ch = int'(a[3:2]);
    case (a[1:0])
      2'd0:    return m_reload[ch];
      2'd1:    return m_count[ch];
      2'd2:    return {28'h0, m_pend[ch], m_ien[ch], m_per[ch], m_en[ch]};
      default: return {31'h0, m_pend[ch]};
    endcase
  endfunction

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i] & m_ien[i];
    return v;
  endfunction

  // One clock of the timer rules, applied to pre-edge model state.
  task automatic model_step(input logic r, input logic s, input logic w,
                            input logic [3:0] a, input logic [31:0] d);
    int  ch = int'(a[3:2]);
    int  rg = int'(a[1:0]);
    bit  wr_rel, wr_ctl, rd_st, fired;
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      wr_rel = s && w && ch == i && rg == 0;
      wr_ctl = s && w && ch == i && rg == 2;
      rd_st  = s && !w && ch == i && rg == 3;
      fired  = !wr_rel && m_ptr == i && m_en[i] && m_count[i] == 1;
      if (wr_rel) begin
        m_reload[i] = d;
        m_count[i]  = d;
      end else if (m_ptr == i && m_en[i]) begin
        if (fired) begin
          m_count[i] = m_reload[i];
          m_pend[i]  = 1;
          if (!m_per[i]) m_en[i] = 0;
        end else begin
          m_count[i] = m_count[i] - 1;
        end
      end
      if (rd_st && !fired) m_pend[i] = 0;
      if (wr_ctl) begin
        m_en[i]  = d[0];
        m_per[i] = d[1];
        m_ien[i] = d[2];
      end
    end
    m_ptr = (m_ptr + 1) % 4;
  endtask

  // Drive one cycle, sample outputs before the edge, compare with the model.
  task automatic cyc(input logic r, input logic s, input logic w,
                     input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    @(negedge clk);
    rst = r; stb = s; we = w; addr = a; data_in = d;
    #1;
    rd       = data_out;
    last_irq = irq;
    last_vec = irq_vec;
    exp_q.push_back(model_read(a));
    check("data_out", data_out, exp_q.pop_front());
    check("irq", 32'(irq), 32'(|model_vec()));
    check("irq_vec", 32'(irq_vec), 32'(model_vec()));
    check("ack", 32'(ack), 32'(s));
    @(posedge clk);
    model_step(r, s, w, a, d);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] v;
    cyc(1'b0, 1'b1, 1'b1, a, d, v);
  endtask

  task automatic rdreg(input logic [3:0] a, output logic [31:0] v);
    cyc(1'b0, 1'b1, 1'b0, a, 32'h0, v);
  endtask

  task automatic obs(input logic [3:0] a, output logic [31:0] v);
    cyc(1'b0, 1'b0, 1'b0, a, 32'h0, v);
  endtask

  task automatic do_rst();
    logic [31:0] v;
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, v);
  endtask

  task automatic idle_until(input int ch, input logic [3:0] a);
    logic [31:0] v;
    int g = 0;
    while (m_ptr != ch && g < 8) begin
      obs(a, v);
      g++;
    end
  endtask

  task automatic run_reset_table();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      rdreg(reset_tbl[i].addr, v);
      check("reset_tbl", v, reset_tbl[i].exp);
      check("reset_irq", 32'(last_irq), 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int e;
    logic r, s, w;
    logic [3:0] a;
    logic [31:0] d;

    for (int i = 0; i < 16; i++) begin
      reset_tbl[i].addr = 4'(i);
      reset_tbl[i].exp  = (i % 4 < 2) ? 32'hFFFF_FFFF : 32'h0;
    end

    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 4'h0; data_in = 32'h0;
    repeat (2) @(posedge clk);
    model_reset();

    run_reset_table();

    // Ch1 periodic, reload 3
    do_rst();
    wr(4'h4, 32'd3);
    wr(4'h6, 32'd7);
    for (int sv = 1; sv <= 3; sv++) begin
      idle_until(1, 4'h6);
      obs(4'h6, v);
      check("ch1_pre_service", v, 32'h7);
    end
    obs(4'h6, v);
    check("ch1_pend", v, 32'hF);
    check("ch1_irq", 32'(last_irq), 32'h1);
    rdreg(4'h5, v);
    check("ch1_count_reload", v, 32'd3);
    rdreg(4'h7, v);
    check("ch1_status", v, 32'h1);
    e = 3;
    while (e < 24) begin
      obs(4'h6, v);
      if (v[3]) break;
      e++;
    end
    check("ch1_period", 32'(e), 32'd12);

    // Ch2 one-shot, reload 2
    do_rst();
    wr(4'h8, 32'd2);
    wr(4'hA, 32'd5);
    for (int sv = 1; sv <= 2; sv++) begin
      idle_until(2, 4'hA);
      obs(4'hA, v);
      check("ch2_pre_service", v, 32'h5);
    end
    obs(4'hA, v);
    check("ch2_oneshot_ctrl", v, 32'hC);
    repeat (8) obs(4'h9, v);
    obs(4'h9, v);
    check("ch2_count_hold", v, 32'd2);
    obs(4'hA, v);
    check("ch2_ctrl_hold", v, 32'hC);

    // Ch0 STATUS read in the expiry cycle
    do_rst();
    wr(4'h0, 32'd2);
    wr(4'h2, 32'd5);
    idle_until(0, 4'h2);
    obs(4'h2, v);
    idle_until(0, 4'h2);
    rdreg(4'h3, v);
    check("ch0_status_at_expiry", v, 32'h0);
    obs(4'h2, v);
    check("ch0_pend_kept", v, 32'hC);
    check("ch0_irq_set", 32'(last_irq), 32'h1);
    rdreg(4'h3, v);
    check("ch0_status_second", v, 32'h1);
    obs(4'h2, v);
    check("ch0_pend_cleared", v, 32'h4);
    check("ch0_irq_clear", 32'(last_irq), 32'h0);

    // Ch3 RELOAD write in its service slot, then reset mid-countdown
    do_rst();
    wr(4'hC, 32'd1);
    wr(4'hE, 32'd1);
    idle_until(3, 4'hD);
    wr(4'hC, 32'd10);
    obs(4'hD, v);
    check("ch3_count_written", v, 32'd10);
    obs(4'hE, v);
    check("ch3_no_pend", v, 32'h1);
    idle_until(3, 4'hD);
    obs(4'hD, v);
    obs(4'hD, v);
    check("ch3_count_dec", v, 32'd9);
    do_rst();
    run_reset_table();

    // Ch0 and ch1 expire in consecutive slots, only ch1 interrupts
    do_rst();
    wr(4'h0, 32'd1);
    wr(4'h4, 32'd1);
    idle_until(2, 4'h0);
    wr(4'h2, 32'd1);
    wr(4'h6, 32'd5);
    obs(4'h2, v);
    obs(4'h2, v);
    obs(4'h2, v);
    check("ch0_ctrl_pend", v, 32'h8);
    check("irq_vec_ch1", 32'(last_vec), 32'h2);
    check("irq_ch1", 32'(last_irq), 32'h1);
    obs(4'h6, v);
    check("ch1_ctrl_pend", v, 32'hC);

    // Random traffic against the model
    do_rst();
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      if (a[1:0] == 2'd0)      d = 32'($urandom_range(0, 6));
      else if (a[1:0] == 2'd2) d = 32'($urandom_range(0, 15));
      else                     d = $urandom;
      cyc(r, s, w, a, d, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
